// File: rtl/pc_pkg.sv
// Shared types for the program-counter generator.
// State and redirect-source encodings used by pc_gen and pc_next_sel.
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } state_t;

   typedef enum logic [1:0] {
      SEQ,
      BR,
      JR,
      TRAP
   } src_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC target selection: redirect priority and target adders.
// Purely combinational; all sums wrap modulo 2^WIDTH.
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter int               INSTR_BYTES = 4,
   parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(32'h0000_0004)
) (
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] rs1,
   input  logic             trap,
   input  logic             jump_reg,
   input  logic             branch_taken,
   output src_t             src,
   output logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] pc_plus
);

   logic [WIDTH-1:0] jr_sum;
   logic [WIDTH-1:0] br_sum;

   always_comb begin
      pc_plus = pc + WIDTH'(INSTR_BYTES);
      jr_sum  = rs1 + imm;
      br_sum  = pc + imm;
      src     = SEQ;
      target  = pc_plus;
      // Requests may overlap, so this is a priority chain.
      if (trap) begin
         src    = TRAP;
         target = TRAP_VECTOR;
      end else if (jump_reg) begin
         src    = JR;
         target = {jr_sum[WIDTH-1:1], 1'b0};
      end else if (branch_taken) begin
         src    = BR;
         target = br_sum;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: BOOT/RUN/HALT control, pc register,
// and a pending-redirect register that survives fetch stalls.
module pc_gen
   import pc_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0004),
   parameter int               INSTR_BYTES  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] imm,
   input  logic             jump_reg,
   input  logic [WIDTH-1:0] rs1,
   input  logic             trap,
   input  logic             halt,
   input  logic             resume,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus,
   output logic             pc_valid,
   output logic             halted
);

   state_t           state;
   logic             pend_valid;
   logic [WIDTH-1:0] pend_target;
   src_t             src;
   logic [WIDTH-1:0] target;
   logic             redir;

   pc_next_sel #(
      .WIDTH      (WIDTH),
      .INSTR_BYTES(INSTR_BYTES),
      .TRAP_VECTOR(TRAP_VECTOR)
   ) u_sel (
      .pc          (pc),
      .imm         (imm),
      .rs1         (rs1),
      .trap        (trap),
      .jump_reg    (jump_reg),
      .branch_taken(branch_taken),
      .src         (src),
      .target      (target),
      .pc_plus     (pc_plus)
   );

   assign redir = (src != SEQ);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BOOT;
         pc          <= RESET_VECTOR;
         pend_valid  <= 1'b0;
         pend_target <= '0;
         pc_valid    <= 1'b0;
         halted      <= 1'b0;
      end else begin
         unique case (state)
            // RESET_VECTOR is presented during BOOT; RUN starts one past it.
            BOOT: begin
               state    <= RUN;
               pc       <= pc_plus;
               pc_valid <= 1'b1;
            end
            RUN: begin
               if (stall) begin
                  if (redir) begin
                     pend_valid  <= 1'b1;
                     pend_target <= target;
                  end
               end else begin
                  pend_valid <= 1'b0;
                  if (src == TRAP) begin
                     pc <= target;
                  end else if (halt) begin
                     state    <= HALT;
                     pc_valid <= 1'b0;
                     halted   <= 1'b1;
                  end else if (redir) begin
                     pc <= target;
                  end else if (pend_valid) begin
                     pc <= pend_target;
                  end else begin
                     pc <= pc_plus;
                  end
               end
            end
            HALT: begin
               if (trap || resume) begin
                  state    <= RUN;
                  pc_valid <= 1'b1;
                  halted   <= 1'b0;
                  if (trap) pc <= TRAP_VECTOR;
               end
            end
            default: begin
               state    <= BOOT;
               pc       <= RESET_VECTOR;
               pc_valid <= 1'b0;
               halted   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random
// stimulus compared against a behavioural next-pc model.
module tb_pc_gen;

   localparam logic [31:0] RV = 32'h0;
   localparam logic [31:0] TV = 32'h4;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] imm;
   logic        jump_reg;
   logic [31:0] rs1;
   logic        trap;
   logic        halt;
   logic        resume;
   logic [31:0] pc;
   logic [31:0] pc_plus;
   logic        pc_valid;
   logic        halted;

   int n_chk  = 0;
   int n_fail = 0;

   // behavioural model
   localparam int M_BOOT = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;
   int          m_mode = M_BOOT;
   logic [31:0] m_pc   = RV;
   bit          m_pend = 0;
   logic [31:0] m_ptgt = '0;

   pc_gen dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .branch_taken(branch_taken),
      .imm         (imm),
      .jump_reg    (jump_reg),
      .rs1         (rs1),
      .trap        (trap),
      .halt        (halt),
      .resume      (resume),
      .pc          (pc),
      .pc_plus     (pc_plus),
      .pc_valid    (pc_valid),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit st, input bit br, input bit jr,
                        input bit tr, input bit ha, input bit re,
                        input logic [31:0] im, input logic [31:0] r1);
      stall = st; branch_taken = br; jump_reg = jr;
      trap = tr; halt = ha; resume = re; imm = im; rs1 = r1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
   endtask

   task automatic model_edge();
      logic [31:0] tgt;
      bit          any;
      any = trap || jump_reg || branch_taken;
      if (trap)              tgt = TV;
      else if (jump_reg)     tgt = (rs1 + imm) & 32'hFFFF_FFFE;
      else if (branch_taken) tgt = m_pc + imm;
      else                   tgt = m_pc + 32'd4;
      if (rst) begin
         m_mode = M_BOOT; m_pc = RV; m_pend = 0; m_ptgt = '0;
      end else if (m_mode == M_BOOT) begin
         m_mode = M_RUN; m_pc = RV + 32'd4;
      end else if (m_mode == M_RUN) begin
         if (stall) begin
            if (any) begin m_pend = 1; m_ptgt = tgt; end
         end else begin
            if (trap)        m_pc = TV;
            else if (halt)   m_mode = M_HALT;
            else if (any)    m_pc = tgt;
            else if (m_pend) m_pc = m_ptgt;
            else             m_pc = m_pc + 32'd4;
            m_pend = 0;
         end
      end else begin
         if (trap) begin m_pc = TV; m_mode = M_RUN; end
         else if (resume) m_mode = M_RUN;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("pc", pc, m_pc);
      chk("pc_plus", pc_plus, m_pc + 32'd4);
      chk("pc_valid", {31'b0, pc_valid}, {31'b0, m_mode == M_RUN});
      chk("halted", {31'b0, halted}, {31'b0, m_mode == M_HALT});
   endtask

   task automatic jump_to(input logic [31:0] a);
      drive(0, 0, 1, 0, 0, 0, 32'h0, a);
      step();
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      // reset, release, idle: pc 0,0,4,8 / pc_valid 0,0,1,1
      step();
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'b0, pc_valid}, 32'h0);
      step();
      rst = 1'b0;
      chk("boot_pc", pc, 32'h0);
      chk("boot_valid", {31'b0, pc_valid}, 32'h0);
      step();
      chk("run1_pc", pc, 32'h4);
      chk("run1_valid", {31'b0, pc_valid}, 32'h1);
      step();
      chk("run2_pc", pc, 32'h8);

      // backward branch and sequential wrap
      jump_to(32'h10);
      drive(0, 1, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0);
      step();
      chk("br_back", pc, 32'h8);
      jump_to(32'hFFFF_FFFC);
      step();
      chk("seq_wrap", pc, 32'h0);

      // jump clears bit0; jump beats branch
      drive(0, 0, 1, 0, 0, 0, 32'h2, 32'h101);
      step();
      chk("jr_bit0", pc, 32'h102);
      drive(0, 1, 1, 0, 0, 0, 32'h10, 32'h200);
      step();
      chk("jr_over_br", pc, 32'h210);

      // branch captured mid-stall, applied on release
      jump_to(32'h20);
      drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      step();
      drive(1, 1, 0, 0, 0, 0, 32'h40, 32'h0);
      step();
      drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      step();
      chk("stall_hold", pc, 32'h20);
      idle();
      step();
      chk("pend_apply", pc, 32'h60);

      // live redirect beats pending one
      drive(1, 1, 0, 0, 0, 0, 32'h100, 32'h0);
      step();
      drive(0, 0, 1, 0, 0, 0, 32'h0, 32'h500);
      step();
      chk("live_wins", pc, 32'h500);

      // trap pending overwritten by later branch in the same stall
      drive(1, 0, 0, 1, 0, 0, 32'h0, 32'h0);
      step();
      drive(1, 1, 0, 0, 0, 0, 32'h8, 32'h0);
      step();
      idle();
      step();
      chk("pend_overwrite", pc, 32'h508);

      // halt / resume / trap from halt
      jump_to(32'h30);
      drive(0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
      step();
      chk("halt_pc", pc, 32'h30);
      chk("halt_flag", {31'b0, halted}, 32'h1);
      chk("halt_valid", {31'b0, pc_valid}, 32'h0);
      idle();
      step();
      drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
      step();
      chk("resume_pc", pc, 32'h30);
      idle();
      step();
      chk("resume_seq", pc, 32'h34);
      drive(0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
      step();
      drive(0, 0, 0, 1, 0, 1, 32'h0, 32'h0);
      step();
      chk("halt_trap", pc, 32'h4);

      // trap beats halt in RUN
      jump_to(32'h80);
      drive(0, 0, 0, 1, 1, 0, 32'h0, 32'h0);
      step();
      chk("trap_halt_pc", pc, 32'h4);
      chk("trap_halt_flag", {31'b0, halted}, 32'h0);

      // reset while a redirect is pending discards it
      drive(1, 1, 0, 0, 0, 0, 32'h300, 32'h0);
      step();
      idle();
      rst = 1'b1;
      step();
      chk("rst_stall_pc", pc, RV);
      rst = 1'b0;
      step();
      step();
      chk("rst_no_pend", pc, RV + 32'd8);

      // random stimulus against the model
      for (int i = 0; i < 400; i++) begin
         rst          = ($urandom_range(0, 99) == 0);
         stall        = ($urandom_range(0, 3) == 0);
         branch_taken = ($urandom_range(0, 3) == 0);
         jump_reg     = ($urandom_range(0, 7) == 0);
         trap         = ($urandom_range(0, 19) == 0);
         halt         = ($urandom_range(0, 15) == 0);
         resume       = ($urandom_range(0, 3) == 0);
         imm          = ($urandom_range(0, 1) == 0) ?
                        32'($urandom_range(0, 255)) - 32'd128 : $urandom;
         rs1          = $urandom;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter: WIDTH, 32, PC and datapath width in bits.
REQ-002 Parameter: RESET_VECTOR, 0, PC value loaded by reset.
REQ-003 Parameter: TRAP_VECTOR, 32'h0000_0004, PC target on trap.
REQ-004 Parameter: INSTR_BYTES, 4, sequential increment.
REQ-005 Clocking: single clock; reset synchronous, active-high.
REQ-006 Port: clk  in  1  sole clock, all state updates on posedge.
REQ-007 Port: rst  in  1  synchronous active-high reset.
REQ-008 Port: stall  in  1  hold PC this cycle.
REQ-009 Port: branch_taken  in  1  redirect to pc+imm.
REQ-010 Port: imm  in  WIDTH  sign-extended offset, or jump offset.
REQ-011 Port: jump_reg  in  1  redirect to (rs1+imm) with bit0 cleared.
REQ-012 Port: rs1  in  WIDTH  jump base.
REQ-013 Port: trap  in  1  redirect to TRAP_VECTOR.
REQ-014 Port: halt  in  1  request halt.
REQ-015 Port: resume  in  1  leave HALT.
REQ-016 Port: pc  out  WIDTH  current PC.
REQ-017 Port: pc_plus  out  WIDTH  pc+INSTR_BYTES, combinational from pc.
REQ-018 Port: pc_valid  out  1  pc is a fetchable address this cycle.
REQ-019 Port: halted  out  1  FSM in HALT.

Function
REQ-020 FSM states BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset release, then RUN unconditionally.
REQ-021 pc_valid SHALL be 1 only in RUN; 0 in BOOT and HALT.
REQ-022 Redirect priority: trap > jump_reg > branch_taken > sequential.
REQ-023 Targets: branch pc+imm; jump (rs1+imm)&~1; trap TRAP_VECTOR; sequential pc+INSTR_BYTES.
REQ-024 All additions modulo 2^WIDTH; carry out discarded, wrap-around silent.
REQ-025 RUN, stall=0, no pending: pc loads the selected target next cycle (1-cycle latency).
REQ-026 RUN, stall=1: pc holds; any redirect present is captured in a pending register (pend_valid, pend_target).
REQ-027 A later redirect during the same stall overwrites the pending target; trap always overwrites.
REQ-028 First stall=0 cycle with pend_valid=1: a live redirect that cycle wins; otherwise pc loads pend_target; pend_valid clears either way.
REQ-029 RUN, halt=1, stall=0, no trap: pc holds, next state HALT; halt ignored while stall=1.
REQ-030 HALT: pc holds; resume=1 -> RUN with pc unchanged; trap=1 -> RUN with pc=TRAP_VECTOR (trap beats resume).
REQ-031 BOOT: all inputs ignored, pc=RESET_VECTOR.
REQ-032 halt and trap same cycle in RUN: trap taken, halt dropped.

Reset
REQ-033 rst=1 at any posedge, any state: pc=RESET_VECTOR, state=BOOT, pend_valid=0, pend_target=0, halted=0, pc_valid=0.
REQ-034 rst mid-stall SHALL discard any pending redirect.

Structure
REQ-035 Package pc_pkg SHALL hold state enum (BOOT/RUN/HALT) and redirect-source enum (SEQ/BR/JR/TRAP).
REQ-036 Sub-module pc_next_sel SHALL be combinational: priority select and target adders.
REQ-037 pc_gen SHALL contain only the FSM, pc register, and pending register.

Verification
REQ-038 Reset, release, 3 idle cycles -> pc 0,0,4,8; pc_valid 0,0,1,1.
REQ-039 pc=0x10, branch_taken, imm=0xFFFF_FFF8 -> next pc=0x08; pc=0xFFFF_FFFC sequential -> 0x0.
REQ-040 jump_reg, rs1=0x101, imm=0x2 -> pc=0x102; jump+branch same cycle -> jump target.
REQ-041 pc=0x20, stall 3 cycles, branch imm=0x40 in stall cycle 2 -> pc holds 0x20, then 0x60.
REQ-042 halt at pc=0x30 -> halted=1, pc_valid=0, pc=0x30; resume -> pc 0x30 then 0x34; trap in HALT -> pc=0x04.
REQ-043 rst while stalled with pending redirect -> pc=RESET_VECTOR, redirect never applied.
